// File: rtl/mem_bus_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if
//   Memory bus interface controller. Accepts a single read or write request
//   and runs it through SETUP -> WAIT -> DONE/FAIL. The request is handed to
//   an asynchronous memory that answers with memory-function-complete (mfc).
//   A WAIT phase that gets no mfc within TIMEOUT cycles ends in FAIL and sets
//   err. All outputs are registered.
//
// Parameters
//   DATA_W   : data path width
//   ADDR_W   : address width
//   TIMEOUT  : maximum number of WAIT cycles (1..255)
//
// Ports
//   clk        in   clock, rising edge active
//   reset      in   asynchronous active-low reset
//   req        in   access request (sampled in IDLE only)
//   we         in   1 = write, 0 = read (sampled with req)
//   req_addr   in   access address (sampled with req)
//   req_wdata  in   write data (sampled with req, writes only)
//   mfc        in   memory-function-complete from memory
//   mem_rdata  in   read data from memory, valid while mfc = 1
//   addr       out  MAR contents driven to memory
//   mem_wdata  out  MBR-out contents driven to memory
//   enable     out  memory strobe
//   rw         out  1 = read, 0 = write
//   rdata      out  last successful read data
//   ack        out  one-cycle completion pulse (success or failure)
//   busy       out  1 in every state except IDLE
//   err        out  last access timed out
// ---------------------------------------------------------------------------
module mem_bus_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              mfc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              enable,
  output logic              rw,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  // The counter holds (WAIT cycle number - 1), so it only ever needs to
  // reach TIMEOUT-1; sized for TIMEOUT to keep the natural range visible.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              enable_r;
  logic              rw_r;
  logic              ack_r;
  logic              busy_r;
  logic              err_r;

  // Access sequencer: state, wait counter and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      addr_r      <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      enable_r    <= 1'b0;
      rw_r        <= 1'b1;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      // ack is a single-cycle pulse unless re-armed below
      ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            addr_r <= req_addr;
            if (we) begin
              mem_wdata_r <= req_wdata;
            end else begin
              mem_wdata_r <= mem_wdata_r;
            end
            rw_r    <= ~we;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          // mfc still high means the memory has not released the previous
          // access; hold off the strobe until it drops.
          if (!mfc) begin
            cnt_r    <= CNT_ZERO;
            enable_r <= 1'b1;
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_SETUP;
          end
        end

        ST_WAIT: begin
          // mfc wins over timeout, including on the last allowed cycle
          if (mfc) begin
            if (rw_r) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
            enable_r <= 1'b0;
            state_r  <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            enable_r <= 1'b0;
            state_r  <= ST_FAIL;
          end else begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
            state_r <= ST_WAIT;
          end
        end

        ST_DONE: begin
          ack_r   <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        ST_FAIL: begin
          ack_r   <= 1'b1;
          err_r   <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          enable_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr      = addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign enable    = enable_r;
  assign rw        = rw_r;
  assign ack       = ack_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mem_bus_if.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_if
//   Directed testbench for mem_bus_if (DATA_W = ADDR_W = 16, TIMEOUT = 15).
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_if;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mfc;
  logic [15:0] mem_rdata;
  logic [15:0] addr;
  logic [15:0] mem_wdata;
  logic        enable;
  logic        rw;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  // running totals of strobe cycles and ack pulses, sampled at rising edges
  int en_tot  = 0;
  int ack_tot = 0;
  int en_base;
  int ack_base;

  mem_bus_if #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mfc       (mfc),
    .mem_rdata (mem_rdata),
    .addr      (addr),
    .mem_wdata (mem_wdata),
    .enable    (enable),
    .rw        (rw),
    .rdata     (rdata),
    .ack       (ack),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enable) en_tot  <= en_tot + 1;
    if (ack)    ack_tot <= ack_tot + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One complete access. mfc is raised on WAIT cycle mfc_cyc (0 = never);
  // a stray req with a different address is pulsed on WAIT cycle poke_cyc.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] md, input int mfc_cyc, input int poke_cyc);
    step();
    req = 1'b1; we = w; req_addr = a; req_wdata = wd; mfc = 1'b0;
    en_base = en_tot; ack_base = ack_tot;
    step();                       // SETUP
    req = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      step();                     // WAIT cycle c
      mfc = (c == mfc_cyc);
      mem_rdata = md;
      if (c == poke_cyc) begin
        req = 1'b1; we = ~w; req_addr = 16'h0099; req_wdata = 16'hDEAD;
      end else begin
        req = 1'b0;
      end
      if (mfc) break;
    end
    step();                       // DONE or FAIL
    mfc = 1'b0; req = 1'b0;
    step();                       // IDLE with ack
    step();
    step();
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; req_addr = 16'h0000;
    req_wdata = 16'h0000; mfc = 1'b0; mem_rdata = 16'h0000;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_addr",   32'(addr),      32'h0);
    check("rst_wdata",  32'(mem_wdata), 32'h0);
    check("rst_rdata",  32'(rdata),     32'h0);
    check("rst_enable", 32'(enable),    32'h0);
    check("rst_ack",    32'(ack),       32'h0);
    check("rst_busy",   32'(busy),      32'h0);
    check("rst_err",    32'(err),       32'h0);
    check("rst_rw",     32'(rw),        32'h1);
    reset = 1'b1;
    step();

    // ---------------- read, minimum latency ----------------
    req = 1'b1; we = 1'b0; req_addr = 16'h0010; req_wdata = 16'h7777;
    en_base = en_tot; ack_base = ack_tot;
    step();                                    // SETUP
    req = 1'b0;
    check("rd_setup_busy",   32'(busy),   32'h1);
    check("rd_setup_enable", 32'(enable), 32'h0);
    check("rd_setup_rw",     32'(rw),     32'h1);
    check("rd_setup_addr",   32'(addr),   32'h0010);
    step();                                    // WAIT 1
    check("rd_wait_enable",  32'(enable), 32'h1);
    mfc = 1'b1; mem_rdata = 16'hBEEF;
    step();                                    // DONE
    mfc = 1'b0; mem_rdata = 16'h0000;
    check("rd_done_ack",     32'(ack),    32'h0);
    check("rd_done_enable",  32'(enable), 32'h0);
    step();                                    // 3 edges after req sample
    check("rd_ack_3edges",   32'(ack),    32'h1);
    check("rd_ack_busy",     32'(busy),   32'h0);
    check("rd_rdata",        32'(rdata),  32'hBEEF);
    check("rd_err",          32'(err),    32'h0);
    check("rd_wdata_kept",   32'(mem_wdata), 32'h0);
    step();
    check("rd_ack_pulse",    32'(ack),    32'h0);
    check("rd_en_cycles",    32'(en_tot - en_base), 32'd1);

    // ---------------- write, mfc on WAIT cycle 4 ----------------
    access(1'b1, 16'h0020, 16'h1234, 16'h5A5A, 4, 0);
    check("wr_addr",      32'(addr),      32'h0020);
    check("wr_wdata",     32'(mem_wdata), 32'h1234);
    check("wr_rw",        32'(rw),        32'h0);
    check("wr_en_cycles", 32'(en_tot - en_base),   32'd4);
    check("wr_acks",      32'(ack_tot - ack_base), 32'd1);
    check("wr_rdata",     32'(rdata),     32'hBEEF);
    check("wr_err",       32'(err),       32'h0);

    // ---------------- timeout ----------------
    access(1'b0, 16'h0030, 16'h0000, 16'h1111, 0, 0);
    check("to_en_cycles", 32'(en_tot - en_base),   32'd15);
    check("to_acks",      32'(ack_tot - ack_base), 32'd1);
    check("to_err",       32'(err),       32'h1);
    check("to_rdata",     32'(rdata),     32'hBEEF);
    check("to_busy",      32'(busy),      32'h0);
    check("to_wdata",     32'(mem_wdata), 32'h1234);

    // next successful access clears err
    access(1'b0, 16'h0040, 16'h0000, 16'h5555, 2, 0);
    check("clr_err",       32'(err),   32'h0);
    check("clr_rdata",     32'(rdata), 32'h5555);
    check("clr_en_cycles", 32'(en_tot - en_base), 32'd2);

    // ---------------- boundary: mfc on WAIT cycle 15 ----------------
    access(1'b0, 16'h0050, 16'h0000, 16'hA5A5, 15, 0);
    check("b15_err",       32'(err),   32'h0);
    check("b15_rdata",     32'(rdata), 32'hA5A5);
    check("b15_en_cycles", 32'(en_tot - en_base),   32'd15);
    check("b15_acks",      32'(ack_tot - ack_base), 32'd1);

    // ---------------- req pulsed during WAIT is ignored ----------------
    access(1'b0, 16'h0060, 16'h0000, 16'h3C3C, 4, 2);
    check("ign_acks",  32'(ack_tot - ack_base), 32'd1);
    check("ign_addr",  32'(addr),  32'h0060);
    check("ign_rw",    32'(rw),    32'h1);
    check("ign_rdata", 32'(rdata), 32'h3C3C);
    check("ign_busy",  32'(busy),  32'h0);
    check("ign_wdata", 32'(mem_wdata), 32'h1234);

    // ---------------- stuck mfc holds SETUP ----------------
    step();
    mfc = 1'b1; mem_rdata = 16'h0000;
    req = 1'b1; we = 1'b0; req_addr = 16'h0070;
    en_base = en_tot; ack_base = ack_tot;
    step();                                    // SETUP
    req = 1'b0;
    step();
    step();
    step();
    check("stk_busy",   32'(busy),   32'h1);
    check("stk_enable", 32'(enable), 32'h0);
    check("stk_ack",    32'(ack_tot - ack_base), 32'd0);
    mfc = 1'b0;
    step();                                    // WAIT 1
    check("stk_wait_enable", 32'(enable), 32'h1);
    mfc = 1'b1; mem_rdata = 16'h0F0F;
    step();                                    // DONE
    mfc = 1'b0;
    step();
    step();
    check("stk_acks",      32'(ack_tot - ack_base), 32'd1);
    check("stk_rdata",     32'(rdata), 32'h0F0F);
    check("stk_en_cycles", 32'(en_tot - en_base), 32'd1);

    // ---------------- reset during WAIT ----------------
    req = 1'b1; we = 1'b0; req_addr = 16'h0080;
    step();                                    // SETUP
    req = 1'b0;
    step();                                    // WAIT 1
    step();                                    // WAIT 2
    check("rw_pre_enable", 32'(enable), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rw_async_enable", 32'(enable), 32'h0);
    check("rw_async_busy",   32'(busy),   32'h0);
    check("rw_async_rdata",  32'(rdata),  32'h0);
    ack_base = ack_tot;
    step();
    reset = 1'b1;
    step();
    step();
    check("rw_no_ack", 32'(ack_tot - ack_base), 32'd0);
    access(1'b0, 16'h0001, 16'h0000, 16'hCAFE, 1, 0);
    check("rw_after_addr",  32'(addr),  32'h0001);
    check("rw_after_rdata", 32'(rdata), 32'hCAFE);
    check("rw_after_acks",  32'(ack_tot - ack_base), 32'd1);
    check("rw_after_err",   32'(err),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
